ym3438_bus_writer: RTL

Host-side bus initiator for the ym3438 CPU port. It accepts register-write requests (bank, register address, data) over a valid/ready handshake. Each request becomes the chip's two-phase write: an address write on ADDRESS={bank,0}, then a data write on ADDRESS={bank,1}. It then waits out the chip busy period before accepting the next request. It sits between a sound-driver/CPU model and the ym3438 `CS/WR/RD/ADDRESS/DATA_i/DATA_o` pins.

---
 rtl/ym3438_bus_pkg.sv | 44 ++++
 rtl/ym3438_bus_writer_if.sv | 28 ++
 rtl/ym3438_bus_strobe.sv | 67 ++++++
 rtl/ym3438_bus_writer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/ym3438_bus_pkg.sv
// Shared types and constants for the ym3438 CPU-port bus writer.
package ym3438_bus_pkg;

  typedef logic [3:0] state_t;
  typedef logic [1:0] chip_addr_t;

  // State = {group, phase}; group picks the bus cycle, phase mirrors the strobe timer.
  localparam logic [1:0] GRP_NONE = 2'b00;
  localparam logic [1:0] GRP_A    = 2'b01;
  localparam logic [1:0] GRP_D    = 2'b10;
  localparam logic [1:0] GRP_R    = 2'b11;

  localparam logic [1:0] PH_IDLE   = 2'd0;
  localparam logic [1:0] PH_SETUP  = 2'd1;
  localparam logic [1:0] PH_STROBE = 2'd2;
  localparam logic [1:0] PH_HOLD   = 2'd3;

  localparam logic [3:0] ST_IDLE     = 4'b0000;
  localparam logic [3:0] ST_WAIT     = 4'b0001;
  localparam logic [3:0] ST_A_SETUP  = 4'b0101;
  localparam logic [3:0] ST_A_STROBE = 4'b0110;
  localparam logic [3:0] ST_A_HOLD   = 4'b0111;
  localparam logic [3:0] ST_D_SETUP  = 4'b1001;
  localparam logic [3:0] ST_D_STROBE = 4'b1010;
  localparam logic [3:0] ST_D_HOLD   = 4'b1011;
  localparam logic [3:0] ST_R_SETUP  = 4'b1101;
  localparam logic [3:0] ST_R_STROBE = 4'b1110;
  localparam logic [3:0] ST_R_HOLD   = 4'b1111;

  localparam chip_addr_t ADDR_A0 = 2'b00;
  localparam chip_addr_t ADDR_D0 = 2'b01;
  localparam chip_addr_t ADDR_A1 = 2'b10;
  localparam chip_addr_t ADDR_D1 = 2'b11;

  localparam int unsigned STATUS_BUSY_BIT = 7;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ym3438_bus_writer_if.sv
// Request handshake plus ym3438 CPU-port pins; master is the writer side.
interface ym3438_bus_writer_if;
  import ym3438_bus_pkg::*;

  logic       req_valid;
  logic       req_ready;
  logic       req_bank;
  logic [7:0] req_addr;
  logic [7:0] req_data;

  logic       CS_n;
  logic       WR_n;
  logic       RD_n;
  chip_addr_t ADDRESS;
  logic [7:0] DATA;
  logic       data_oe;
  logic [7:0] status_i;

  modport master (
    input  req_valid, req_bank, req_addr, req_data, status_i,
    output req_ready, CS_n, WR_n, RD_n, ADDRESS, DATA, data_oe
  );

  modport slave (
    output req_valid, req_bank, req_addr, req_data, status_i,
    input  req_ready, CS_n, WR_n, RD_n, ADDRESS, DATA, data_oe
  );
endinterface

// File: rtl/ym3438_bus_strobe.sv
// Setup/strobe/hold phase timer shared by the address, data and status-read cycles.
module ym3438_bus_strobe
  import ym3438_bus_pkg::*;
#(
  parameter int unsigned T_SETUP  = 2,
  parameter int unsigned T_STROBE = 4,
  parameter int unsigned T_HOLD   = 2
) (
  input  logic       MCLK,
  input  logic       reset,
  input  logic       start,
  output logic [1:0] adv_c,
  output logic       sample_c,
  output logic       done_c
);
  localparam int unsigned CNT_W = $clog2(max3(T_SETUP, T_STROBE, T_HOLD) + 1);

  logic [1:0]       phase_q, phase_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_adv, cnt_nxt;

  // Free-running advance, a function of the registers only.
  always_comb begin
    adv_c    = phase_q;
    cnt_adv  = cnt_q;
    sample_c = 1'b0;
    done_c   = 1'b0;
    if (cnt_q != '0) begin
      cnt_adv = cnt_q - CNT_W'(1);
    end else begin
      case (phase_q)
        PH_SETUP: begin
          adv_c   = PH_STROBE;
          cnt_adv = CNT_W'(T_STROBE - 1);
        end
        PH_STROBE: begin
          adv_c    = PH_HOLD;
          cnt_adv  = CNT_W'(T_HOLD - 1);
          sample_c = 1'b1;
        end
        PH_HOLD: begin
          adv_c  = PH_IDLE;
          done_c = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    phase_nxt = adv_c;
    cnt_nxt   = cnt_adv;
    if (start) begin
      phase_nxt = PH_SETUP;
      cnt_nxt   = CNT_W'(T_SETUP - 1);
    end
  end

  always_ff @(posedge MCLK) begin
    if (reset) begin
      phase_q <= PH_IDLE;
      cnt_q   <= '0;
    end else begin
      phase_q <= phase_nxt;
      cnt_q   <= cnt_nxt;
    end
  end
endmodule

// File: rtl/ym3438_bus_writer.sv
// ym3438 CPU-port write initiator: address write, data write, then busy wait.
// Define YM3438_BUS_BUSY_POLL_EN to replace the fixed wait with status polling.
module ym3438_bus_writer
  import ym3438_bus_pkg::*;
#(
  parameter int unsigned T_SETUP   = 2,
  parameter int unsigned T_STROBE  = 4,
  parameter int unsigned T_HOLD    = 2,
  parameter int unsigned BUSY_WAIT = 192,
  parameter int unsigned POLL_MAX  = 64
) (
  input  logic                MCLK,
  input  logic                reset,
  ym3438_bus_writer_if.master bus,
  output logic                idle_o,
  output logic                err_o
);
  state_t     state_q, state_nxt;
  logic       bank_q, bank_nxt;
  logic [7:0] addr_q, addr_nxt, wdata_q, wdata_nxt;
  logic       cache_valid_q, cache_valid_nxt;
  logic [8:0] cache_key_q, cache_key_nxt;
  logic       start_c, done_c, sample_c, strobe_c;
  logic [1:0] adv_c, grp_c, ph_c;
  logic       cs_n_nxt, wr_n_nxt, rd_n_nxt, data_oe_nxt, ready_nxt, err_nxt;
  chip_addr_t address_nxt;
  logic [7:0] data_nxt;
  logic       unused_c;

`ifdef YM3438_BUS_BUSY_POLL_EN
  localparam int unsigned POLL_W = $clog2(POLL_MAX + 1);
  logic [POLL_W-1:0] poll_q, poll_nxt;
  logic              busy_q, busy_nxt;
  assign unused_c = ^{32'(BUSY_WAIT)};
`else
  localparam int unsigned WAIT_W = $clog2(BUSY_WAIT + 1);
  logic [WAIT_W-1:0] wait_q, wait_nxt;
  assign unused_c = ^{bus.status_i, sample_c, 32'(POLL_MAX)};
`endif

  ym3438_bus_strobe #(
    .T_SETUP (T_SETUP),
    .T_STROBE(T_STROBE),
    .T_HOLD  (T_HOLD)
  ) u_strobe (
    .MCLK    (MCLK),
    .reset   (reset),
    .start   (start_c),
    .adv_c   (adv_c),
    .sample_c(sample_c),
    .done_c  (done_c)
  );

  always_comb begin
    state_nxt       = state_q;
    bank_nxt        = bank_q;
    addr_nxt        = addr_q;
    wdata_nxt       = wdata_q;
    cache_valid_nxt = cache_valid_q;
    cache_key_nxt   = cache_key_q;
    start_c         = 1'b0;
    err_nxt         = err_o;
`ifdef YM3438_BUS_BUSY_POLL_EN
    poll_nxt        = poll_q;
    busy_nxt        = busy_q;
`else
    wait_nxt        = wait_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          bank_nxt  = bus.req_bank;
          addr_nxt  = bus.req_addr;
          wdata_nxt = bus.req_data;
          start_c   = 1'b1;
          // Same register as the last address write: the chip still has it latched.
          if (cache_valid_q && cache_key_q == {bus.req_bank, bus.req_addr})
            state_nxt = ST_D_SETUP;
          else
            state_nxt = ST_A_SETUP;
        end
      end
      ST_A_SETUP, ST_A_STROBE, ST_A_HOLD: begin
        if (done_c) begin
          start_c         = 1'b1;
          state_nxt       = ST_D_SETUP;
          cache_valid_nxt = 1'b1;
          cache_key_nxt   = {bank_q, addr_q};
        end else begin
          state_nxt = {GRP_A, adv_c};
        end
      end
      ST_D_SETUP, ST_D_STROBE, ST_D_HOLD: begin
        if (done_c) begin
`ifdef YM3438_BUS_BUSY_POLL_EN
          start_c   = 1'b1;
          state_nxt = ST_R_SETUP;
          poll_nxt  = '0;
`else
          state_nxt = ST_WAIT;
          wait_nxt  = WAIT_W'(BUSY_WAIT - 1);
`endif
        end else begin
          state_nxt = {GRP_D, adv_c};
        end
      end
`ifdef YM3438_BUS_BUSY_POLL_EN
      ST_R_SETUP, ST_R_STROBE, ST_R_HOLD: begin
        if (sample_c) busy_nxt = bus.status_i[STATUS_BUSY_BIT];
        if (done_c) begin
          if (!busy_q) begin
            state_nxt = ST_IDLE;
          end else if (poll_q == POLL_W'(POLL_MAX - 1)) begin
            err_nxt   = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            poll_nxt  = poll_q + POLL_W'(1);
            start_c   = 1'b1;
            state_nxt = ST_R_SETUP;
          end
        end else begin
          state_nxt = {GRP_R, adv_c};
        end
      end
`else
      ST_WAIT: begin
        if (wait_q == '0) state_nxt = ST_IDLE;
        else              wait_nxt  = wait_q - WAIT_W'(1);
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase

    // Pin values for the upcoming state, registered below.
    grp_c       = state_nxt[3:2];
    ph_c        = state_nxt[1:0];
    strobe_c    = (grp_c != GRP_NONE) && (ph_c == PH_STROBE);
    cs_n_nxt    = !strobe_c;
    wr_n_nxt    = !(strobe_c && grp_c != GRP_R);
`ifdef YM3438_BUS_BUSY_POLL_EN
    rd_n_nxt    = !(strobe_c && grp_c == GRP_R);
`else
    rd_n_nxt    = 1'b1;
`endif
    data_oe_nxt = (grp_c == GRP_A) || (grp_c == GRP_D);
    address_nxt = ADDR_A0;
    data_nxt    = '0;
    case (grp_c)
      GRP_A: begin
        address_nxt = bank_nxt ? ADDR_A1 : ADDR_A0;
        data_nxt    = addr_nxt;
      end
      GRP_D: begin
        address_nxt = bank_nxt ? ADDR_D1 : ADDR_D0;
        data_nxt    = wdata_nxt;
      end
      GRP_R:   address_nxt = bank_nxt ? ADDR_A1 : ADDR_A0;
      default: ;
    endcase
    ready_nxt = (state_nxt == ST_IDLE);
  end

  always_ff @(posedge MCLK) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      bank_q        <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      cache_valid_q <= 1'b0;
      cache_key_q   <= '0;
`ifdef YM3438_BUS_BUSY_POLL_EN
      poll_q        <= '0;
      busy_q        <= 1'b0;
`else
      wait_q        <= '0;
`endif
      bus.CS_n      <= 1'b1;
      bus.WR_n      <= 1'b1;
      bus.RD_n      <= 1'b1;
      bus.ADDRESS   <= ADDR_A0;
      bus.DATA      <= '0;
      bus.data_oe   <= 1'b0;
      bus.req_ready <= 1'b0;
      idle_o        <= 1'b1;
      err_o         <= 1'b0;
    end else begin
      state_q       <= state_nxt;
      bank_q        <= bank_nxt;
      addr_q        <= addr_nxt;
      wdata_q       <= wdata_nxt;
      cache_valid_q <= cache_valid_nxt;
      cache_key_q   <= cache_key_nxt;
`ifdef YM3438_BUS_BUSY_POLL_EN
      poll_q        <= poll_nxt;
      busy_q        <= busy_nxt;
`else
      wait_q        <= wait_nxt;
`endif
      bus.CS_n      <= cs_n_nxt;
      bus.WR_n      <= wr_n_nxt;
      bus.RD_n      <= rd_n_nxt;
      bus.ADDRESS   <= address_nxt;
      bus.DATA      <= data_nxt;
      bus.data_oe   <= data_oe_nxt;
      bus.req_ready <= ready_nxt;
      idle_o        <= ready_nxt;
      err_o         <= err_nxt;
    end
  end
endmodule
